traffic_intersection_ctrl: RTL

Parametrised multi-approach traffic-light controller, the next generation of the single-approach light FSM. It sequences green → yellow → all-red clearance round-robin over NUM_DIRS approaches, with per-direction green times, a clock prescaler, latched pedestrian walk requests and a red-flash fault mode on invalid configuration. It sits between the configuration register bank and the lamp/walk-signal drivers.

---
 rtl/traffic_intersection_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Round-robin multi-approach traffic-light controller: green -> yellow -> all-red
// clearance per approach, with pedestrian walk latching and a red-flash fault mode.
module traffic_intersection_ctrl #(
  parameter int NUM_DIRS   = 2,
  parameter int TW         = 6,
  parameter int TICK_DIV   = 1,
  parameter int FLASH_HALF = 4,
  localparam int DW        = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [NUM_DIRS*TW-1:0] i_green_time,
  input  logic [TW-1:0]          i_yellow_time,
  input  logic [TW-1:0]          i_clear_time,
  input  logic [NUM_DIRS-1:0]    i_ped_req,
  output logic [3*NUM_DIRS-1:0]  o_light,
  output logic [NUM_DIRS-1:0]    o_walk,
  output logic [DW-1:0]          o_active_dir,
  output logic                   o_error_status
);

  // state    | meaning
  // S_CLEAR  | all approaches red; r_dir is the approach that goes green next
  // S_GREEN  | approach r_dir green, all others red
  // S_YELLOW | approach r_dir yellow, all others red
  // S_FLASH  | invalid configuration; every lamp flashes red

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FL_MAX  = FW'(FLASH_HALF - 1);
  localparam logic [DW-1:0] DIR_MAX = DW'(NUM_DIRS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_GREEN, S_YELLOW, S_FLASH} state_t;

  state_t                r_state,   w_state_nxt;
  logic [DW-1:0]         r_dir,     w_dir_nxt;
  logic [TW-1:0]         r_cnt,     w_cnt_nxt;
  logic [PW-1:0]         r_pre,     w_pre_nxt;
  logic [FW-1:0]         r_fl_cnt,  w_fl_cnt_nxt;
  logic                  r_fl_on,   w_fl_on_nxt;
  logic [NUM_DIRS-1:0]   r_pending, w_pending_nxt;
  logic [NUM_DIRS-1:0]   r_walk,    w_walk_nxt;
  logic [3*NUM_DIRS-1:0] r_light,   w_light_nxt;
  logic                  r_error;

  logic [TW-1:0] w_green [NUM_DIRS];
  logic          w_invalid;
  logic          w_tick;
  logic [TW-1:0] w_clear_load;

  always_comb begin
    w_invalid = (i_yellow_time == '0);
    for (int d = 0; d < NUM_DIRS; d++) begin
      w_green[d] = i_green_time[d*TW +: TW];
      if (w_green[d] == '0) w_invalid = 1'b1;
    end
  end

  // A zero clearance still gets one unit of all-red.
  assign w_clear_load = (i_clear_time == '0) ? '0 : i_clear_time - TW'(1);
  assign w_tick       = (r_pre == PRE_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_cnt_nxt     = r_cnt;
    w_pre_nxt     = r_pre;
    w_fl_cnt_nxt  = r_fl_cnt;
    w_fl_on_nxt   = r_fl_on;
    w_pending_nxt = r_pending | i_ped_req;
    w_walk_nxt    = r_walk;

    if (r_state != S_FLASH && w_invalid) begin
      w_state_nxt  = S_FLASH;
      w_fl_cnt_nxt = '0;
      w_fl_on_nxt  = 1'b1;
      w_walk_nxt   = '0;
    end else if (r_state == S_FLASH) begin
      if (!w_invalid) begin
        w_state_nxt = S_CLEAR;
        w_dir_nxt   = '0;
        w_cnt_nxt   = w_clear_load;
        w_pre_nxt   = '0;
      end else if (r_fl_cnt == FL_MAX) begin
        w_fl_cnt_nxt = '0;
        w_fl_on_nxt  = ~r_fl_on;
      end else begin
        w_fl_cnt_nxt = r_fl_cnt + FW'(1);
      end
    end else if (i_enable) begin
      if (!w_tick) begin
        w_pre_nxt = r_pre + PW'(1);
      end else begin
        w_pre_nxt = '0;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - TW'(1);
        end else begin
          case (r_state)
            S_CLEAR: begin
              w_state_nxt              = S_GREEN;
              w_cnt_nxt                = w_green[r_dir] - TW'(1);
              w_walk_nxt               = '0;
              w_walk_nxt[r_dir]        = r_pending[r_dir];
              w_pending_nxt[r_dir]     = i_ped_req[r_dir];
            end
            S_GREEN: begin
              w_state_nxt = S_YELLOW;
              w_cnt_nxt   = i_yellow_time - TW'(1);
              w_walk_nxt  = '0;
            end
            S_YELLOW: begin
              w_state_nxt = S_CLEAR;
              w_dir_nxt   = (r_dir == DIR_MAX) ? '0 : r_dir + DW'(1);
              w_cnt_nxt   = w_clear_load;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_light_nxt = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (w_state_nxt == S_FLASH)
        w_light_nxt[3*d +: 3] = w_fl_on_nxt ? 3'b100 : 3'b000;
      else if (w_state_nxt == S_GREEN && w_dir_nxt == DW'(d))
        w_light_nxt[3*d +: 3] = 3'b001;
      else if (w_state_nxt == S_YELLOW && w_dir_nxt == DW'(d))
        w_light_nxt[3*d +: 3] = 3'b010;
      else
        w_light_nxt[3*d +: 3] = 3'b100;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_CLEAR;
      r_dir     <= '0;
      r_cnt     <= '0;
      r_pre     <= '0;
      r_fl_cnt  <= '0;
      r_fl_on   <= 1'b1;
      r_pending <= '0;
      r_walk    <= '0;
      r_light   <= {NUM_DIRS{3'b100}};
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pre     <= w_pre_nxt;
      r_fl_cnt  <= w_fl_cnt_nxt;
      r_fl_on   <= w_fl_on_nxt;
      r_pending <= w_pending_nxt;
      r_walk    <= w_walk_nxt;
      r_light   <= w_light_nxt;
      r_error   <= (w_state_nxt == S_FLASH);
    end
  end

  assign o_light        = r_light;
  assign o_walk         = r_walk;
  assign o_active_dir   = r_dir;
  assign o_error_status = r_error;

endmodule
